// File: rtl/intr_ctrl_pkg.sv
// Shared register map, VECTOR field layout and bus request type for the interrupt controller.
package intr_ctrl_pkg;
  localparam int DATA_W        = 32;
  localparam int ID_W          = 5;
  localparam int VEC_VALID_BIT = 31;

  // Word index of each register; byte offset is index * 4 (Addr[4:2]).
  typedef enum logic [2:0] {
    REG_RAW      = 3'd0,
    REG_PENDING  = 3'd1,
    REG_ENABLE   = 3'd2,
    REG_MODE     = 3'd3,
    REG_POLARITY = 3'd4,
    REG_VECTOR   = 3'd5,
    REG_ACK      = 3'd6,
    REG_NONE     = 3'd7
  } reg_sel_e;

  typedef struct packed {
    logic              wr;
    reg_sel_e          sel;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  function automatic logic [DATA_W-1:0] vector_word(input logic valid, input logic [ID_W-1:0] id);
    logic [DATA_W-1:0] w;
    w                = '0;
    w[VEC_VALID_BIT] = valid;
    w[ID_W-1:0]      = id;
    return w;
  endfunction
endpackage

// File: rtl/intr_src_cell.sv
// One interrupt source: polarity normalisation, edge/level detect and the pending bit.
module intr_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic pol,
  input  logic clr,
  output logic norm,
  output logic pending
);
  logic prev;

  assign norm = src ^ pol;

  // prev samples in both modes so a level->edge switch never fakes a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= norm;
      if (!mode)              pending <= norm;
      else if (norm && !prev) pending <= 1'b1;
      else if (clr)           pending <= 1'b0;
    end
  end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: register file, per-source cells, lowest-index priority encoder, registered nIRQ.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CS_N,
  input  logic             RD_N,
  input  logic             WR_N,
  input  logic [11:0]      Addr,
  input  logic [31:0]      DataIn,
  output logic [31:0]      DataOut,
  input  logic [N_SRC-1:0] IrqSrc,
  output logic             nIRQ
);
  bus_req_t         req;
  logic [N_SRC-1:0] enable, mode, polarity;
  logic [N_SRC-1:0] norm, pending, active, clr;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign req.wr    = !CS_N && !WR_N;
  assign req.sel   = reg_sel_e'(Addr[4:2]);
  assign req.data  = DataIn;
  assign unused_bits = &{1'b0, Addr, DataIn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= '0;
      mode     <= '0;
      polarity <= '0;
    end else if (req.wr) begin
      case (req.sel)
        REG_ENABLE:   enable   <= req.data[N_SRC-1:0];
        REG_MODE:     mode     <= req.data[N_SRC-1:0];
        REG_POLARITY: polarity <= req.data[N_SRC-1:0];
        default: ;
      endcase
    end
  end

  // W1C and ACK both funnel into the per-source clear; cells ignore it in level mode.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++)
      clr[i] = req.wr && ((req.sel == REG_PENDING && req.data[i]) ||
                          (req.sel == REG_ACK && req.data[ID_W-1:0] == ID_W'(i)));
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    intr_src_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .src     (IrqSrc[g]),
      .mode    (mode[g]),
      .pol     (polarity[g]),
      .clr     (clr[g]),
      .norm    (norm[g]),
      .pending (pending[g])
    );
  end

  assign active = pending & enable;

  always_comb begin
    irq_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) irq_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nIRQ <= 1'b1;
    else        nIRQ <= ~|active;
  end

  always_comb begin
    rd_word = '0;
    case (req.sel)
      REG_RAW:      rd_word[N_SRC-1:0] = norm;
      REG_PENDING:  rd_word[N_SRC-1:0] = pending;
      REG_ENABLE:   rd_word[N_SRC-1:0] = enable;
      REG_MODE:     rd_word[N_SRC-1:0] = mode;
      REG_POLARITY: rd_word[N_SRC-1:0] = polarity;
      REG_VECTOR:   rd_word            = vector_word(|active, irq_id);
      default: ;
    endcase
    DataOut = (!CS_N && !RD_N) ? rd_word : '0;
  end
endmodule
